// File: rtl/mw_writeback_stage.sv
// mw_writeback_stage
// Memory-to-writeback stage of the RV32I pipeline. Holds the retiring
// instruction, aligns synchronous load data, selects the writeback value
// for the register file and keeps the 64-bit instret counter.
module mw_writeback_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ex_valid_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] ex_alu_i,
    input  logic [XLEN-1:0] ex_pc4_i,
    input  logic [4:0]      ex_rd_i,
    input  logic            ex_regwen_i,
    input  logic [1:0]      ex_wbsel_i,
    input  logic [2:0]      ex_funct3_i,
    input  logic [1:0]      ex_addr_lo_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic [XLEN-1:0] rf_data_o,
    output logic [4:0]      rf_waddr_o,
    output logic            rf_wen_o,
    output logic            wb_valid_o,
    output logic [63:0]     instret_o
);

    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    logic            r_valid;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_pc4;
    logic [4:0]      r_rd;
    logic            r_regwen;
    logic [1:0]      r_wbsel;
    logic [2:0]      r_funct3;
    logic [1:0]      r_addr_lo;
    logic [63:0]     r_instret;

    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_data;
    logic            w_retire;

    // Stage register: a stall freezes everything (flush included), otherwise capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid   <= 1'b0;
            r_alu     <= '0;
            r_pc4     <= '0;
            r_rd      <= '0;
            r_regwen  <= 1'b0;
            r_wbsel   <= '0;
            r_funct3  <= '0;
            r_addr_lo <= '0;
        end else if (!stall_i) begin
            r_valid   <= ex_valid_i & ~flush_i;
            r_alu     <= ex_alu_i;
            r_pc4     <= ex_pc4_i;
            r_rd      <= ex_rd_i;
            r_regwen  <= ex_regwen_i;
            r_wbsel   <= ex_wbsel_i;
            r_funct3  <= ex_funct3_i;
            r_addr_lo <= ex_addr_lo_i;
        end
    end

    // Pick the addressed byte and halfword out of the memory word.
    always_comb begin
        w_byte = dmem_rdata_i[7:0];
        case (r_addr_lo)
            2'd0: w_byte = dmem_rdata_i[7:0];
            2'd1: w_byte = dmem_rdata_i[15:8];
            2'd2: w_byte = dmem_rdata_i[23:16];
            2'd3: w_byte = dmem_rdata_i[31:24];
            default: w_byte = dmem_rdata_i[7:0];
        endcase
        w_half = r_addr_lo[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    end

    // Extend the selected byte/half according to the load size and sign.
    always_comb begin
        case (r_funct3)
            3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
            3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
            3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
            default: w_load = dmem_rdata_i;
        endcase
    end

    // Writeback source select; codes 0 and 3 both take the ALU result.
    always_comb begin
        case (r_wbsel)
            WB_MEM:  w_data = w_load;
            WB_PC4:  w_data = r_pc4;
            default: w_data = r_alu;
        endcase
    end

    assign w_retire   = r_valid & ~stall_i;
    assign rf_data_o  = w_data;
    assign rf_waddr_o = r_rd;
    assign rf_wen_o   = w_retire & r_regwen & (r_rd != 5'd0);
    assign wb_valid_o = r_valid;
    assign instret_o  = r_instret;

    // Retired-instruction counter; natural 64-bit wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + 64'd1;
        end
    end

endmodule

// File: tb/tb_mw_writeback_stage.sv
// Testbench for mw_writeback_stage: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_mw_writeback_stage;

    logic        clk_i;
    logic        rst_ni;
    logic        ex_valid_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] ex_alu_i;
    logic [31:0] ex_pc4_i;
    logic [4:0]  ex_rd_i;
    logic        ex_regwen_i;
    logic [1:0]  ex_wbsel_i;
    logic [2:0]  ex_funct3_i;
    logic [1:0]  ex_addr_lo_i;
    logic [31:0] dmem_rdata_i;
    logic [31:0] rf_data_o;
    logic [4:0]  rf_waddr_o;
    logic        rf_wen_o;
    logic        wb_valid_o;
    logic [63:0] instret_o;

    mw_writeback_stage #(.XLEN(32)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ex_valid_i   (ex_valid_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .ex_alu_i     (ex_alu_i),
        .ex_pc4_i     (ex_pc4_i),
        .ex_rd_i      (ex_rd_i),
        .ex_regwen_i  (ex_regwen_i),
        .ex_wbsel_i   (ex_wbsel_i),
        .ex_funct3_i  (ex_funct3_i),
        .ex_addr_lo_i (ex_addr_lo_i),
        .dmem_rdata_i (dmem_rdata_i),
        .rf_data_o    (rf_data_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wen_o     (rf_wen_o),
        .wb_valid_o   (wb_valid_o),
        .instret_o    (instret_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the instruction currently held by the stage.
    logic        m_valid;
    logic [31:0] m_alu;
    logic [31:0] m_pc4;
    logic [4:0]  m_rd;
    logic        m_regwen;
    logic [1:0]  m_wbsel;
    logic [2:0]  m_f3;
    logic [1:0]  m_off;
    logic [63:0] m_instret;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] exp_data();
        if (m_wbsel == 2'd1) return exp_load(m_f3, m_off, dmem_rdata_i);
        if (m_wbsel == 2'd2) return m_pc4;
        return m_alu;
    endfunction

    task automatic model_reset();
        m_valid   = 1'b0;
        m_alu     = '0;
        m_pc4     = '0;
        m_rd      = '0;
        m_regwen  = 1'b0;
        m_wbsel   = '0;
        m_f3      = '0;
        m_off     = '0;
        m_instret = '0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".data"},    rf_data_o,  exp_data());
        check_eq({tag, ".waddr"},   rf_waddr_o, m_rd);
        check_eq({tag, ".wen"},     rf_wen_o,   m_valid && m_regwen && (m_rd != 0) && !stall_i);
        check_eq({tag, ".valid"},   wb_valid_o, m_valid);
        check_eq({tag, ".instret"}, instret_o,  m_instret);
    endtask

    task automatic set_ex(input logic v, input logic fl, input logic st, input logic [31:0] alu,
                          input logic [31:0] pc4, input logic [4:0] rd, input logic rw,
                          input logic [1:0] wb, input logic [2:0] f3, input logic [1:0] off);
        ex_valid_i   = v;
        flush_i      = fl;
        stall_i      = st;
        ex_alu_i     = alu;
        ex_pc4_i     = pc4;
        ex_rd_i      = rd;
        ex_regwen_i  = rw;
        ex_wbsel_i   = wb;
        ex_funct3_i  = f3;
        ex_addr_lo_i = off;
    endtask

    // Advance one clock: model retirement and capture, return at the next falling edge.
    task automatic tick();
        @(posedge clk_i);
        if (m_valid && !stall_i) m_instret = m_instret + 64'd1;
        if (!stall_i) begin
            m_valid  = ex_valid_i && !flush_i;
            m_alu    = ex_alu_i;
            m_pc4    = ex_pc4_i;
            m_rd     = ex_rd_i;
            m_regwen = ex_regwen_i;
            m_wbsel  = ex_wbsel_i;
            m_f3     = ex_funct3_i;
            m_off    = ex_addr_lo_i;
        end
        @(negedge clk_i);
    endtask

    task automatic step(input string tag);
        #1;
        check_outputs(tag);
        tick();
    endtask

    logic [31:0] ld_word;
    logic [2:0]  ld_f3  [6] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [1:0]  ld_off [6] = '{2'd0, 2'd2, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] ld_exp [6] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0080,
                                32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

    initial begin
        rst_ni       = 1'b0;
        dmem_rdata_i = '0;
        set_ex(0, 0, 0, '0, '0, '0, 0, '0, '0, '0);
        model_reset();
        repeat (2) @(negedge clk_i);
        #1;
        check_outputs("por");
        rst_ni = 1'b1;

        // Reset asserted mid-stall with a valid instruction held.
        set_ex(1, 0, 0, 32'hDEAD_BEEF, 32'h0000_0040, 5'd3, 1, 2'd0, 3'd2, 2'd3);
        step("rst_a");
        set_ex(1, 0, 0, 32'h0BAD_F00D, 32'h0000_0044, 5'd4, 1, 2'd0, 3'd2, 2'd1);
        step("rst_b");
        set_ex(0, 0, 1, '0, '0, '0, 0, '0, '0, '0);
        #1;
        check_eq("pre_rst.valid", wb_valid_o, 1'b1);
        #1;
        rst_ni = 1'b0;
        #1;
        check_eq("rst.valid",   wb_valid_o, 1'b0);
        check_eq("rst.wen",     rf_wen_o,   1'b0);
        check_eq("rst.waddr",   rf_waddr_o, 5'd0);
        check_eq("rst.data",    rf_data_o,  32'd0);
        check_eq("rst.instret", instret_o,  64'd0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        set_ex(0, 0, 0, '0, '0, '0, 0, '0, '0, '0);
        step("rel");
        #1;
        check_eq("rel.wen",     rf_wen_o,  1'b0);
        check_eq("rel.instret", instret_o, 64'd0);

        // ALU writeback, then PC+4 writeback.
        set_ex(1, 0, 0, 32'h1234_5678, 32'h0000_0100, 5'd5, 1, 2'd0, 3'd2, 2'd0);
        tick();
        set_ex(1, 0, 0, 32'hAAAA_0000, 32'h0000_0104, 5'd6, 1, 2'd2, 3'd2, 2'd0);
        #1;
        check_eq("alu.wen",     rf_wen_o,   1'b1);
        check_eq("alu.waddr",   rf_waddr_o, 5'd5);
        check_eq("alu.data",    rf_data_o,  32'h1234_5678);
        check_eq("alu.instret", instret_o,  64'd0);
        tick();
        set_ex(0, 0, 0, '0, '0, '0, 0, '0, '0, '0);
        #1;
        check_eq("alu.instret1", instret_o, 64'd1);
        check_eq("pc4.data",     rf_data_o, 32'h0000_0104);
        check_eq("pc4.waddr",    rf_waddr_o, 5'd6);
        step("pc4");

        // Load alignment against a fixed memory word.
        for (int i = 0; i < 6; i++) begin
            set_ex(1, 0, 0, {30'h0, ld_off[i]}, 32'h0000_0200, 5'd10, 1, 2'd1, ld_f3[i], ld_off[i]);
            tick();
            set_ex(0, 0, 0, '0, '0, '0, 0, '0, '0, '0);
            ld_word      = 32'h80FF_7F01;
            dmem_rdata_i = ld_word;
            #1;
            check_eq($sformatf("load%0d", i), rf_data_o, ld_exp[i]);
            step("load");
        end

        // x0 destination and non-writing instructions still retire.
        set_ex(1, 0, 0, 32'h5555_5555, 32'h0, 5'd0, 1, 2'd0, 3'd2, 2'd0);
        tick();
        set_ex(1, 0, 0, 32'h6666_6666, 32'h0, 5'd7, 0, 2'd0, 3'd2, 2'd0);
        #1;
        check_eq("x0.wen", rf_wen_o, 1'b0);
        step("x0");
        #1;
        check_eq("norw.wen",   rf_wen_o,   1'b0);
        check_eq("norw.waddr", rf_waddr_o, 5'd7);
        set_ex(0, 0, 0, '0, '0, '0, 0, '0, '0, '0);
        step("norw");

        // Stall with flush held: rd 9 waits, then retires; flushed newcomer stays invalid.
        set_ex(1, 0, 0, 32'h0000_0999, 32'h0, 5'd9, 1, 2'd0, 3'd2, 2'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_ex(1, 1, 1, 32'h7777_0000 + i, 32'h0, 5'd17, 1, 2'd0, 3'd2, 2'd0);
            #1;
            check_eq("stall.wen",   rf_wen_o,   1'b0);
            check_eq("stall.waddr", rf_waddr_o, 5'd9);
            check_eq("stall.data",  rf_data_o,  32'h0000_0999);
            step("stall");
        end
        set_ex(1, 1, 0, 32'h7777_7777, 32'h0, 5'd17, 1, 2'd0, 3'd2, 2'd0);
        #1;
        check_eq("unstall.wen",   rf_wen_o,   1'b1);
        check_eq("unstall.waddr", rf_waddr_o, 5'd9);
        step("unstall");
        set_ex(0, 0, 0, '0, '0, '0, 0, '0, '0, '0);
        #1;
        check_eq("flushed.valid", wb_valid_o, 1'b0);
        check_eq("flushed.wen",   rf_wen_o,   1'b0);
        step("flushed");

        // Counter wrap, then 100 back-to-back retirements.
        set_ex(1, 0, 0, 32'h1, 32'h0, 5'd1, 1, 2'd0, 3'd2, 2'd0);
        tick();
        force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_instret;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check_eq("wrap.pre", instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        #1;
        check_eq("wrap.zero", instret_o, 64'd0);
        for (int i = 0; i < 100; i++) begin
            set_ex(1, 0, 0, $urandom, $urandom, 5'($urandom_range(1, 31)), 1, 2'd0, 3'd2, 2'd0);
            tick();
        end
        #1;
        check_eq("b2b.count", instret_o, 64'd100);
        check_outputs("b2b");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] alu;
            alu = $urandom;
            set_ex(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 4) == 0), alu, $urandom,
                   ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                   ($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom), alu[1:0]);
            dmem_rdata_i = $urandom;
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mw_writeback_stage.md
# mw_writeback_stage

Memory-to-writeback pipeline stage of the 5-stage RV32I core, sitting directly upstream of the register file. It registers the retiring instruction's control and results at the execute/memory boundary, aligns and sign-extends synchronous data-memory read data, selects the writeback value, and drives the register file's write data, address and enable. It also maintains a 64-bit retired-instruction counter for the `instret` CSR.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk_i  in  1`: core clock; all state updates on the rising edge.
- `rst_ni  in  1`: asynchronous, active-low reset.
- `ex_valid_i  in  1`: an instruction is presented for capture.
- `stall_i  in  1`: hold the stage register and suppress retirement.
- `flush_i  in  1`: kill the instruction being captured.
- `ex_alu_i  in  32`: ALU result.
- `ex_pc4_i  in  32`: PC+4 of the instruction.
- `ex_rd_i  in  5`: destination register.
- `ex_regwen_i  in  1`: instruction writes rd.
- `ex_wbsel_i  in  2`: writeback source. 0 = ALU, 1 = memory, 2 = PC+4, 3 = ALU.
- `ex_funct3_i  in  3`: load size and sign.
- `ex_addr_lo_i  in  2`: byte offset of the load address (`ex_alu_i[1:0]`).
- `dmem_rdata_i  in  32`: word read from data memory; valid in the cycle after capture.
- `rf_data_o  out  32`: write data to the register file.
- `rf_waddr_o  out  5`: write address to the register file.
- `rf_wen_o  out  1`: write enable to the register file.
- `wb_valid_o  out  1`: the stage holds a valid instruction.
- `instret_o  out  64`: count of retired instructions.

## Operation
- **Stage register** (valid, alu, pc4, rd, regwen, wbsel, funct3, addr_lo):
  - `stall_i = 1`: all fields hold; `flush_i` is ignored. Upstream must keep asserting flush until the stall clears.
  - `stall_i = 0`: data fields load from the `ex_*` inputs; valid loads `ex_valid_i & ~flush_i`.
- **Load alignment** (combinational, from the registered funct3/addr_lo and `dmem_rdata_i`):
  - Byte: `rdata[8*addr_lo +: 8]`.
  - Half: `rdata[16*addr_lo[1] +: 16]`; `addr_lo[0]` is ignored.
  - 000 LB: sign-extended byte. 100 LBU: zero-extended byte.
  - 001 LH: sign-extended half. 101 LHU: zero-extended half.
  - 010 and all other codes: full word.
- **Writeback mux:** `rf_data_o` is selected by the registered wbsel, including when valid = 0.
- **Register-file write:** `rf_wen_o = valid & regwen & (rd != 0) & ~stall_i`.
- **Register-file address:** `rf_waddr_o` = registered rd.
- **Retirement:** an instruction retires when `valid & ~stall_i`, whether or not it writes rd.
- **Retired counter:** `instret_o` increments by 1 on each retirement and wraps from 2^64−1 to 0.
- **Reset (`rst_ni` low, asynchronous):**
  - Clears valid, regwen, rd, wbsel, all data fields and `instret_o`.
  - `rf_wen_o` = 0, `wb_valid_o` = 0, `rf_waddr_o` = 0, `rf_data_o` = 0 (wbsel = ALU, alu = 0).
  - Deassertion takes effect at the first rising edge with `rst_ni` high. Reset mid-stall discards the held instruction.

## Timing
- Edge N captures the `ex_*` inputs.
- During cycle N→N+1, `dmem_rdata_i` must be valid and stable. `rf_*` outputs are combinational in this cycle.
- The register file commits at edge N+1 if `rf_wen_o = 1`.
- Stalled cycles:
  - `rf_wen_o` stays 0.
  - Memory must hold `dmem_rdata_i` stable for the stalled instruction.
  - The write happens in the first cycle with `stall_i` low.
- `instret_o` updates at the same edge as the register-file write: edge N+1, or the first unstalled edge.
- No internal bypass. The hazard unit forwards from `rf_data_o`/`rf_waddr_o`/`rf_wen_o` in the same cycle.
- Back-to-back instructions with no stall: one capture and one retirement per cycle.

## Test plan
- **Reset:** assert `rst_ni` = 0 mid-cycle with valid = 1 → all outputs 0 immediately, with no clock edge; after release with `ex_valid_i` = 0 → `rf_wen_o` = 0 and `instret_o` = 0.
- **ALU and PC+4 writeback:**
  - Capture rd = 5, wbsel = 0, alu = 0x1234_5678 → next cycle `rf_wen_o` = 1, `rf_waddr_o` = 5, `rf_data_o` = 0x1234_5678; `instret_o` goes 0→1.
  - Capture wbsel = 2, pc4 = 0x104 → `rf_data_o` = 0x104.
- **Load alignment** with `dmem_rdata_i` = 0x80FF_7F01:
  - LB off 0 → 0x0000_0001; LB off 2 → 0xFFFF_FFFF; LBU off 3 → 0x0000_0080.
  - LH off 2 → 0xFFFF_80FF; LHU off 0 → 0x0000_7F01; LW → 0x80FF_7F01.
- **x0 and non-writing instructions:**
  - rd = 0, regwen = 1 → `rf_wen_o` = 0 and `instret_o` still increments.
  - regwen = 0, rd = 7 → `rf_wen_o` = 0.
- **Stall with flush:** capture rd = 9, then hold `stall_i` = 1 for 3 cycles with `flush_i` = 1 and new `ex_*` values:
  - During the stall: `rf_wen_o` = 0, `rf_waddr_o` = 9, `instret_o` unchanged.
  - When the stall clears: one write to rd 9, `instret_o` +1, and the flushed incoming instruction leaves valid = 0.
- **Counter wrap:** force `instret_o` to 0xFFFF_FFFF_FFFF_FFFF and retire one instruction → `instret_o` = 0; 100 back-to-back retirements → +100.
